// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: opcode and response byte values plus FSM state encoding
// shared by the UART command responder and its timer.
package uart_cmd_pkg;
    localparam logic [7:0] OP_WR     = 8'h57;
    localparam logic [7:0] OP_RD     = 8'h52;
    localparam logic [7:0] RSP_WR_OK = 8'h4B;
    localparam logic [7:0] RSP_RD_OK = 8'h44;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LATCH,
        S_EXEC,
        S_RESP0,
        S_RESP1
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return b == OP_WR || b == OP_RD;
    endfunction
endpackage

// File: rtl/uart_cmd_timer.sv
// uart_cmd_timer: inter-byte timeout counter; expired is high on the
// CYCLES-th consecutive enabled cycle since the last clear.
module uart_cmd_timer #(
    parameter int CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + W'(1);
    end

    assign expired = enable && count == W'(CYCLES - 1);
endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: parses W/R command frames from an RX FIFO, accesses a
// register port and pushes K / D+data / E responses into a TX FIFO.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int NUM_REGS       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_fifo_empty,
    output logic       rx_fifo_rd_en,
    input  logic [7:0] rx_fifo_data,
    input  logic       tx_fifo_full,
    output logic       tx_fifo_wr_en,
    output logic [7:0] tx_fifo_data,
    input  logic       line_err,
    output logic       reg_wr_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] err_count
);
    localparam logic [8:0] NREGS = 9'(NUM_REGS);

    state_t     state, state_n;
    logic [1:0] byte_idx, idx_n;
    logic [7:0] opcode, op_n, addr_n, wdata_n, resp, resp_n, rdata, rdata_n;
    logic       run, pop_st, resp_st, expired, abort, addr_ok, err_inc;

    assign pop_st  = state == S_IDLE || state == S_POP;
    assign resp_st = state == S_RESP0 || state == S_RESP1;
    assign addr_ok = {1'b0, reg_addr} < NREGS;
    assign abort   = (line_err && !resp_st) || expired;

    // run keeps the FIFO untouched until the first edge after reset release
    assign rx_fifo_rd_en = run && pop_st && !rx_fifo_empty && !abort;
    assign tx_fifo_wr_en = resp_st && !tx_fifo_full;
    assign tx_fifo_data  = state == S_RESP1 ? rdata : state == S_RESP0 ? resp : 8'h00;
    assign reg_wr_en     = state == S_EXEC && opcode == OP_WR && addr_ok;
    assign busy          = byte_idx != 2'd0 || !pop_st;
    assign timeout_err   = expired;

    uart_cmd_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (rx_fifo_rd_en || state == S_IDLE),
        .enable (state == S_POP && byte_idx != 2'd0 && rx_fifo_empty),
        .expired(expired)
    );

    always_comb begin
        state_n = state;
        idx_n   = byte_idx;
        op_n    = opcode;
        addr_n  = reg_addr;
        wdata_n = reg_wdata;
        resp_n  = resp;
        rdata_n = rdata;
        err_inc = 1'b0;
        if (abort) begin
            state_n = S_IDLE;
            err_inc = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_POP: state_n = rx_fifo_rd_en ? S_LATCH : state;
                S_LATCH: begin
                    idx_n   = byte_idx + 2'd1;
                    op_n    = byte_idx == 2'd0 ? rx_fifo_data : opcode;
                    addr_n  = byte_idx == 2'd1 ? rx_fifo_data : reg_addr;
                    wdata_n = byte_idx == 2'd2 ? rx_fifo_data : reg_wdata;
                    if (byte_idx == 2'd0 && !is_opcode(rx_fifo_data)) begin
                        state_n = S_RESP0;
                        resp_n  = RSP_ERR;
                        err_inc = 1'b1;
                    end else begin
                        state_n = (byte_idx == 2'd2 || (byte_idx == 2'd1 && opcode == OP_RD)) ? S_EXEC : S_POP;
                    end
                end
                S_EXEC: begin
                    resp_n  = !addr_ok ? RSP_ERR : opcode == OP_WR ? RSP_WR_OK : RSP_RD_OK;
                    rdata_n = reg_rdata;
                    err_inc = !addr_ok;
                    state_n = S_RESP0;
                end
                S_RESP0: state_n = tx_fifo_full ? S_RESP0 : resp == RSP_RD_OK ? S_RESP1 : S_IDLE;
                S_RESP1: state_n = tx_fifo_full ? S_RESP1 : S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
        if (state_n == S_IDLE)
            idx_n = 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            byte_idx  <= 2'd0;
            opcode    <= 8'h00;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            resp      <= 8'h00;
            rdata     <= 8'h00;
            err_count <= 8'h00;
            run       <= 1'b0;
        end else begin
            state     <= state_n;
            byte_idx  <= idx_n;
            opcode    <= op_n;
            reg_addr  <= addr_n;
            reg_wdata <= wdata_n;
            resp      <= resp_n;
            rdata     <= rdata_n;
            err_count <= (err_inc && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
            run       <= 1'b1;
        end
    end
endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000; inter-byte timeout in clk cycles.
REQ-002 SHALL have parameter NUM_REGS, default 16; register addresses 0..NUM_REGS-1 are valid.
REQ-003 SHALL have ports: clk  in  1  single clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: rx_fifo_empty  in  1  RX FIFO empty; rx_fifo_rd_en  out  1  RX FIFO pop; rx_fifo_data  in  8  RX FIFO data, valid the cycle after rd_en.
REQ-005 SHALL have ports: tx_fifo_full  in  1  TX FIFO full; tx_fifo_wr_en  out  1  TX FIFO push; tx_fifo_data  out  8  byte pushed.
REQ-006 SHALL have ports: line_err  in  1  pulse on UART parity, framing or overrun error.
REQ-007 SHALL have ports: reg_wr_en  out  1  one-cycle write strobe; reg_addr  out  8  register address; reg_wdata  out  8  write data; reg_rdata  in  8  combinational read data for reg_addr.
REQ-008 SHALL have ports: busy  out  1  frame in progress; timeout_err  out  1  one-cycle pulse on abort; err_count  out  8  saturating error counter.

Function
REQ-009 Frame format SHALL be: opcode byte, address byte, then a data byte for writes only; 'W'=0x57 write, 'R'=0x52 read.
REQ-010 Responses SHALL be: write OK -> 0x4B; read OK -> 0x44 then register value; error -> 0x45.
REQ-011 FSM states SHALL be IDLE, POP, LATCH, EXEC, RESP0, RESP1.
REQ-012 IDLE/POP: when rx_fifo_empty=0, assert rx_fifo_rd_en for exactly one cycle, then go to LATCH; never pop while empty.
REQ-013 LATCH: capture rx_fifo_data into field byte_idx (0 opcode, 1 addr, 2 data); increment byte_idx.
REQ-014 Opcode not 'W' or 'R' SHALL go directly to RESP0 with 0x45 without consuming further bytes.
REQ-015 Frame complete (R after addr, W after data) SHALL go to EXEC; otherwise go to POP to wait for the next byte.
REQ-016 EXEC, addr < NUM_REGS: write -> reg_wr_en=1 for one cycle with reg_addr/reg_wdata stable; read -> latch reg_rdata the same cycle.
REQ-017 EXEC, addr >= NUM_REGS: no reg_wr_en; response 0x45.
REQ-018 RESP0/RESP1: push one byte per cycle with tx_fifo_wr_en=1 only while tx_fifo_full=0; hold byte and state while full.
REQ-019 Read OK SHALL push 0x44 then data on consecutive non-full cycles; other responses push one byte; then return to IDLE with byte_idx=0.
REQ-020 Timeout: with byte_idx>0 in POP and rx_fifo_empty=1 for TIMEOUT_CYCLES consecutive cycles, abort to IDLE, pulse timeout_err, no response.
REQ-021 line_err=1 in any state other than RESP0/RESP1 SHALL abort the frame to IDLE, no response; during RESP the response completes.
REQ-022 err_count SHALL increment on each 0x45 response, timeout or line_err abort; saturate at 255; simultaneous events count once.
REQ-023 Timeout counter SHALL reset on every pop and on entry to IDLE.
REQ-024 busy SHALL be 1 whenever byte_idx>0 or state is not IDLE/POP.

Reset
REQ-025 On rst_n=0, state SHALL be IDLE, byte_idx 0, counters 0, all outputs 0, asynchronously, including mid-frame and mid-response.
REQ-026 After reset release, no FIFO access SHALL occur before the first rising clk edge.

Structure
REQ-027 Opcode/response constants and state encoding SHALL live in package uart_cmd_pkg.
REQ-028 The inter-byte timeout counter SHALL be sub-module uart_cmd_timer (clear, enable, expired).

Verification
REQ-029 RX bytes 0x57,0x03,0xA5 -> reg_wr_en one cycle with addr 0x03, wdata 0xA5; TX 0x4B; err_count 0.
REQ-030 RX 0x52,0x03 with reg_rdata=0x5C -> TX 0x44 then 0x5C; no reg_wr_en.
REQ-031 RX 0x52,0x20 (NUM_REGS=16) -> TX 0x45; RX 0x11 -> TX 0x45 immediately; err_count=2.
REQ-032 RX 0x57 only, TIMEOUT_CYCLES=50 -> timeout_err pulse after 50 idle cycles; no TX; next frame processed normally.
REQ-033 Read response with tx_fifo_full held 10 cycles -> no push while full; 0x44,data pushed after release, order intact.
REQ-034 rst_n low mid-RESP1 -> all outputs 0 immediately; line_err mid-frame -> abort, err_count+1.
